// File: rtl/drbe_ctrl_pkg.sv
// Shared widths, table geometry and FSM encoding for the delay-table sender.
package drbe_ctrl_pkg;

  localparam int DELAY_LENGTH = 14;
  localparam int OBJ_ID_WIDTH = 2;
  localparam int N_OBJ        = 4;
  localparam int TAIL_LEN     = 4;
  localparam int IDX_W        = $clog2(N_OBJ);
  localparam int TAIL_W       = $clog2(TAIL_LEN);
  localparam int NUM_W        = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    SEND   = 3'd2,
    GAP    = 3'd3,
    TAIL   = 3'd4,
    FINISH = 3'd5
  } state_e;

  typedef struct packed {
    logic [DELAY_LENGTH-1:0] delay;
    logic [OBJ_ID_WIDTH-1:0] obj;
  } entry_t;

  // Index of the final entry to stream; requests above the table size are clamped.
  function automatic logic [IDX_W-1:0] last_index(input logic [NUM_W-1:0] n);
    logic [NUM_W-1:0] m;
    if (n > NUM_W'(N_OBJ)) begin
      m = NUM_W'(N_OBJ);
    end else begin
      m = n;
    end
    return IDX_W'(m - NUM_W'(1));
  endfunction

endpackage

// File: rtl/delay_entry_table.sv
// Four-entry {delay, object id} table: one synchronous write port and one
// combinational read port.
module delay_entry_table
  import drbe_ctrl_pkg::*;
(
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_addr,
  input  logic [DELAY_LENGTH-1:0] wr_delay,
  input  logic [OBJ_ID_WIDTH-1:0] wr_obj,
  input  logic [IDX_W-1:0]        rd_addr,
  output logic [DELAY_LENGTH-1:0] rd_delay,
  output logic [OBJ_ID_WIDTH-1:0] rd_obj
);

  entry_t mem_q [N_OBJ];

  // Table storage, cleared by reset
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_OBJ; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr].delay <= wr_delay;
      mem_q[wr_addr].obj   <= wr_obj;
    end
  end

  assign rd_delay = mem_q[rd_addr].delay;
  assign rd_obj   = mem_q[rd_addr].obj;

endmodule

// File: rtl/delay_table_sender.sv
// Streams the configured delay table to the local controller, either as a
// boot-up sequence (framed by boot_up) or as a scenario update (closed by a commit pulse).
module delay_table_sender
  import drbe_ctrl_pkg::*;
(
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    cfg_wr_en,
  input  logic [IDX_W-1:0]        cfg_wr_addr,
  input  logic [DELAY_LENGTH-1:0] cfg_wr_delay,
  input  logic [OBJ_ID_WIDTH-1:0] cfg_wr_obj,
  input  logic [NUM_W-1:0]        cfg_num_entries,
  input  logic                    send_boot,
  input  logic                    send_update,
  output logic                    boot_up,
  output logic                    input_valid,
  output logic                    glob_scen_noc_input_valid,
  output logic [DELAY_LENGTH-1:0] delay_matrix_element,
  output logic [OBJ_ID_WIDTH-1:0] obj_id_element,
  output logic                    boot_up_table_update,
  output logic                    busy,
  output logic                    done
);

  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);

  state_e                  state_q, state_d;
  logic                    mode_boot_q, mode_boot_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [TAIL_W-1:0]       tail_q, tail_d;

  logic                    boot_up_q, boot_up_d;
  logic                    in_valid_q, in_valid_d;
  logic                    upd_valid_q, upd_valid_d;
  logic [DELAY_LENGTH-1:0] delay_q, delay_d;
  logic [OBJ_ID_WIDTH-1:0] obj_q, obj_d;
  logic                    tbl_upd_q, tbl_upd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    accept_s;
  logic                    tbl_wr_s;
  logic [DELAY_LENGTH-1:0] rd_delay_s;
  logic [OBJ_ID_WIDTH-1:0] rd_obj_s;

  assign accept_s = (state_q == IDLE) && (send_boot || send_update)
                    && (cfg_num_entries != NUM_W'(0));
  assign tbl_wr_s = cfg_wr_en && (state_q == IDLE);

  // The read address follows the next count so the output register captures the entry on entry to SEND.
  delay_entry_table u_table (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .wr_en    (tbl_wr_s),
    .wr_addr  (cfg_wr_addr),
    .wr_delay (cfg_wr_delay),
    .wr_obj   (cfg_wr_obj),
    .rd_addr  (cnt_d),
    .rd_delay (rd_delay_s),
    .rd_obj   (rd_obj_s)
  );

  // Next-state, counter and command-capture logic
  always_comb begin
    state_d     = state_q;
    mode_boot_d = mode_boot_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    tail_d      = tail_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          mode_boot_d = send_boot;
          last_d      = last_index(cfg_num_entries);
          cnt_d       = '0;
          tail_d      = '0;
          state_d     = send_boot ? LEAD : SEND;
        end else begin
          state_d = IDLE;
        end
      end
      LEAD: state_d = SEND;
      SEND: begin
        if (cnt_q == last_q) begin
          state_d = TAIL;
          tail_d  = '0;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = SEND;
        cnt_d   = cnt_q + IDX_W'(1);
      end
      TAIL: begin
        if (tail_q == TAIL_LAST) begin
          state_d = FINISH;
        end else begin
          tail_d = tail_q + TAIL_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so every output leaves a flop
  always_comb begin
    busy_d      = (state_d != IDLE);
    boot_up_d   = mode_boot_d && (state_d inside {LEAD, SEND, GAP, TAIL});
    in_valid_d  = (state_d == SEND) && mode_boot_d;
    upd_valid_d = (state_d == SEND) && !mode_boot_d;
    done_d      = (state_d == FINISH);
    tbl_upd_d   = (state_d == FINISH) && !mode_boot_d;
    if (state_d == SEND) begin
      delay_d = rd_delay_s;
      obj_d   = rd_obj_s;
    end else begin
      delay_d = delay_q;
      obj_d   = obj_q;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mode_boot_q <= 1'b0;
      cnt_q       <= '0;
      last_q      <= '0;
      tail_q      <= '0;
      boot_up_q   <= 1'b0;
      in_valid_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      delay_q     <= '0;
      obj_q       <= '0;
      tbl_upd_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_boot_q <= mode_boot_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      tail_q      <= tail_d;
      boot_up_q   <= boot_up_d;
      in_valid_q  <= in_valid_d;
      upd_valid_q <= upd_valid_d;
      delay_q     <= delay_d;
      obj_q       <= obj_d;
      tbl_upd_q   <= tbl_upd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign boot_up                   = boot_up_q;
  assign input_valid               = in_valid_q;
  assign glob_scen_noc_input_valid = upd_valid_q;
  assign delay_matrix_element      = delay_q;
  assign obj_id_element            = obj_q;
  assign boot_up_table_update      = tbl_upd_q;
  assign busy                      = busy_q;
  assign done                      = done_q;

endmodule

// File: tb/tb_delay_table_sender.sv
// Self-checking bench: expected entries are queued when a command is issued
// and popped as the design presents them; framing signals are checked every cycle.
module tb_delay_table_sender;

  logic        CLK;
  logic        reset_n;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_addr;
  logic [13:0] cfg_wr_delay;
  logic [1:0]  cfg_wr_obj;
  logic [2:0]  cfg_num_entries;
  logic        send_boot;
  logic        send_update;
  logic        boot_up;
  logic        input_valid;
  logic        glob_scen_noc_input_valid;
  logic [13:0] delay_matrix_element;
  logic [1:0]  obj_id_element;
  logic        boot_up_table_update;
  logic        busy;
  logic        done;

  typedef struct {
    int          cyc;
    logic [13:0] d;
    logic [1:0]  o;
  } exp_t;

  exp_t        sbq[$];
  logic [13:0] m_delay[4];
  logic [1:0]  m_obj[4];
  logic [13:0] hold_d;
  logic [1:0]  hold_o;
  int          total = 0;
  int          bad = 0;

  delay_table_sender dut (
    .CLK                       (CLK),
    .reset_n                   (reset_n),
    .cfg_wr_en                 (cfg_wr_en),
    .cfg_wr_addr               (cfg_wr_addr),
    .cfg_wr_delay              (cfg_wr_delay),
    .cfg_wr_obj                (cfg_wr_obj),
    .cfg_num_entries           (cfg_num_entries),
    .send_boot                 (send_boot),
    .send_update               (send_update),
    .boot_up                   (boot_up),
    .input_valid               (input_valid),
    .glob_scen_noc_input_valid (glob_scen_noc_input_valid),
    .delay_matrix_element      (delay_matrix_element),
    .obj_id_element            (obj_id_element),
    .boot_up_table_update      (boot_up_table_update),
    .busy                      (busy),
    .done                      (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      m_delay[i] = 14'd0;
      m_obj[i]   = 2'd0;
    end
    hold_d = 14'd0;
    hold_o = 2'd0;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [13:0] d, input logic [1:0] o);
    cfg_wr_en    = 1'b1;
    cfg_wr_addr  = a;
    cfg_wr_delay = d;
    cfg_wr_obj   = o;
    @(posedge CLK);
    #1;
    cfg_wr_en = 1'b0;
    m_delay[a] = d;
    m_obj[a]   = o;
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({boot_up, input_valid, glob_scen_noc_input_valid, delay_matrix_element, obj_id_element,
         boot_up_table_update, busy, done} !== 22'd0) begin
      bad++;
      $display("FAIL %s: outputs bu=%b iv=%b uv=%b d=%0d o=%0d tu=%b busy=%b done=%b, required all 0",
               tag, boot_up, input_valid, glob_scen_noc_input_valid, delay_matrix_element,
               obj_id_element, boot_up_table_update, busy, done);
    end
  endtask

  // inj bit0: send_update pulse during the stream; bit1: table write during the stream
  task automatic run_stream(input logic b, input logic u, input logic [2:0] n, input int inj, input string tag);
    logic is_boot;
    int   n_eff, first, fin, last_c;
    exp_t e;
    is_boot = b;
    n_eff   = (n > 3'd4) ? 4 : int'(n);
    first   = is_boot ? 2 : 1;
    fin     = (n_eff == 0) ? 0 : first + 2 * (n_eff - 1) + 5;
    last_c  = (n_eff == 0) ? 6 : fin + 2;
    for (int i = 0; i < n_eff; i++) begin
      e.cyc = first + 2 * i;
      e.d   = m_delay[i];
      e.o   = m_obj[i];
      sbq.push_back(e);
    end
    send_boot       = b;
    send_update     = u;
    cfg_num_entries = n;
    @(posedge CLK);
    #1;
    send_boot   = 1'b0;
    send_update = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      if (sbq.size() > 0 && sbq[0].cyc < c) begin
        total++;
        bad++;
        $display("FAIL %s missed_entry: no valid at cycle %0d, required one", tag, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (input_valid || glob_scen_noc_input_valid) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL %s spurious_valid: valid at cycle %0d, required none", tag, c);
        end else begin
          e = sbq.pop_front();
          if (c !== e.cyc || delay_matrix_element !== e.d || obj_id_element !== e.o ||
              input_valid !== is_boot || glob_scen_noc_input_valid !== !is_boot) begin
            bad++;
            $display("FAIL %s entry: cyc=%0d d=%0d o=%0d iv=%b uv=%b, required cyc=%0d d=%0d o=%0d iv=%b uv=%b",
                     tag, c, delay_matrix_element, obj_id_element, input_valid,
                     glob_scen_noc_input_valid, e.cyc, e.d, e.o, is_boot, !is_boot);
          end
          hold_d = e.d;
          hold_o = e.o;
        end
      end else begin
        total++;
        if (delay_matrix_element !== hold_d || obj_id_element !== hold_o) begin
          bad++;
          $display("FAIL %s hold: cycle %0d d=%0d o=%0d, required d=%0d o=%0d",
                   tag, c, delay_matrix_element, obj_id_element, hold_d, hold_o);
        end
      end
      total++;
      if (boot_up !== (is_boot && c < fin) || done !== (c == fin) ||
          boot_up_table_update !== (!is_boot && c == fin) || busy !== (c <= fin)) begin
        bad++;
        $display("FAIL %s framing: cycle %0d bu=%b done=%b tu=%b busy=%b, required bu=%b done=%b tu=%b busy=%b",
                 tag, c, boot_up, done, boot_up_table_update, busy, is_boot && c < fin,
                 c == fin, !is_boot && c == fin, c <= fin);
      end
      if (c == 3 && inj[0]) send_update = 1'b1;
      if (c == 3 && inj[1]) begin
        cfg_wr_en    = 1'b1;
        cfg_wr_addr  = 2'd0;
        cfg_wr_delay = 14'd999;
        cfg_wr_obj   = 2'd3;
      end
      @(posedge CLK);
      #1;
      send_update = 1'b0;
      cfg_wr_en   = 1'b0;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s leftover: %0d entries not streamed, required 0", tag, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset_state");
    reset_n = 1'b1;
  endtask

  task automatic test_boot();
    write_entry(2'd0, 14'd50, 2'd1);
    write_entry(2'd1, 14'd10000, 2'd0);
    write_entry(2'd2, 14'd12000, 2'd2);
    run_stream(1'b1, 1'b0, 3'd3, 0, "boot");
  endtask

  task automatic test_update();
    run_stream(1'b0, 1'b1, 3'd3, 0, "update");
  endtask

  task automatic test_both_and_busy_cmd();
    run_stream(1'b1, 1'b1, 3'd3, 1, "both_cmd");
    run_stream(1'b0, 1'b0, 3'd0, 0, "after_busy_cmd");
  endtask

  task automatic test_zero_and_clamp();
    run_stream(1'b1, 1'b0, 3'd0, 0, "zero_n");
    write_entry(2'd3, 14'd16383, 2'd3);
    run_stream(1'b0, 1'b1, 3'd7, 0, "clamp7");
  endtask

  task automatic test_cfg_busy();
    run_stream(1'b0, 1'b1, 3'd2, 2, "cfg_busy");
    run_stream(1'b1, 1'b0, 3'd1, 0, "cfg_after");
  endtask

  task automatic test_reset_abort();
    send_boot       = 1'b1;
    cfg_num_entries = 3'd3;
    @(posedge CLK);
    #1;
    send_boot = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: busy=%b, required 1", busy);
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("abort_immediate");
    repeat (2) begin
      @(posedge CLK);
      #1;
      check_all_zero("abort_held");
    end
    reset_n = 1'b1;
    clear_model();
    @(posedge CLK);
    #1;
    check_all_zero("abort_released");
    run_stream(1'b0, 1'b1, 3'd3, 0, "post_abort_update");
  endtask

  initial begin
    reset_n         = 1'b0;
    cfg_wr_en       = 1'b0;
    cfg_wr_addr     = 2'd0;
    cfg_wr_delay    = 14'd0;
    cfg_wr_obj      = 2'd0;
    cfg_num_entries = 3'd0;
    send_boot       = 1'b0;
    send_update     = 1'b0;
    clear_model();
    test_reset();
    test_boot();
    test_update();
    test_both_and_busy_cmd();
    test_zero_and_clamp();
    test_cfg_busy();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
